// File: rtl/camera_capture_pkg.sv
// Shared encodings for the camera capture block: pixel modes, FSM states, RGB332 field layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package camera_capture_pkg;

  // Camera pixel format selector; the reserved code falls back to RGB565.
  typedef enum logic [1:0] {
    MODE_RGB565   = 2'd0,
    MODE_RGB444   = 2'd1,
    MODE_YUV_GRAY = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // Capture FSM. BYTE0: first byte of a pixel is held. BYTE1: pixel pair just completed.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_BYTE0     = 2'd2,
    ST_BYTE1     = 2'd3
  } state_e;

  // RGB332 output byte field positions.
  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

endpackage

// File: rtl/camera_capture_pixel_pack.sv
// Converts a camera byte pair into one RGB332 pixel according to the latched mode.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module camera_pixel_pack
  import camera_capture_pkg::*;
(
  input  mode_e      mode,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  output logic [7:0] pix
);

  // Bits of the byte pair that no format ever uses.
  logic unused_bits;
  assign unused_bits = ^{b0[4], b1[1:0]};

  // Select the field slices per pixel format; reserved mode decodes as RGB565.
  always_comb begin
    pix = '0;
    case (mode)
      MODE_RGB444: begin
        pix[RGB_R_MSB:RGB_R_LSB] = b0[3:1];
        pix[RGB_G_MSB:RGB_G_LSB] = b1[7:5];
        pix[RGB_B_MSB:RGB_B_LSB] = b1[3:2];
      end
      MODE_YUV_GRAY: begin
        pix[RGB_R_MSB:RGB_R_LSB] = b0[7:5];
        pix[RGB_G_MSB:RGB_G_LSB] = b0[7:5];
        pix[RGB_B_MSB:RGB_B_LSB] = b0[7:6];
      end
      default: begin
        pix[RGB_R_MSB:RGB_R_LSB] = b0[7:5];
        pix[RGB_G_MSB:RGB_G_LSB] = b0[2:0];
        pix[RGB_B_MSB:RGB_B_LSB] = b1[4:3];
      end
    endcase
  end

endmodule

// File: rtl/camera_capture.sv
// Captures a parallel camera frame, packs byte pairs to RGB332 and writes them to a frame buffer.
// Latency: one cycle from the second-byte sample to W_EN; one cycle from VSYNC sample to state change.
// Backpressure: none; the camera cannot be stalled, so every write strobe must be accepted.
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int FRAME_W = 176,
  parameter int FRAME_H = 144,
  parameter int ADDR_W  = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        CAM_DATA,
  input  logic              CAM_HREF,
  input  logic              CAM_VSYNC,
  input  logic [1:0]        MODE,
  input  logic              CAPTURE_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR,
  output logic              BUSY
);

  localparam logic [ADDR_W-1:0] FW_A    = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] FH_A    = ADDR_W'(FRAME_H);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              vsync_q, vsync_d;
  logic [7:0]        b0_q, b0_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              err_acc_q, err_acc_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              w_en_q, w_en_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;

  logic              vsync_rise;
  logic              line_end;
  logic [7:0]        pix;
  logic [ADDR_W:0]   base_sum;

  // Second byte comes straight from the pins so the pixel is ready on the sampling edge.
  camera_pixel_pack u_pack (
    .mode (mode_q),
    .b0   (b0_q),
    .b1   (CAM_DATA),
    .pix  (pix)
  );

  assign vsync_rise = CAM_VSYNC & ~vsync_q;
  // Line base grows by one line width, pinned at all-ones instead of wrapping.
  assign base_sum   = {1'b0, base_q} + {1'b0, FW_A};

  // Next-state logic: frame boundary has priority over line/byte handling.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    vsync_d   = CAM_VSYNC;
    b0_d      = b0_q;
    x_d       = x_q;
    y_d       = y_q;
    base_d    = base_q;
    err_acc_d = err_acc_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_en_d    = 1'b0;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
    line_end  = 1'b0;

    if (vsync_rise && (state_q != ST_IDLE)) begin
      // Close the frame; a re-armed capture starts the next one on this same edge.
      done_d    = 1'b1;
      ferr_d    = err_acc_q | (y_q != FH_A);
      x_d       = '0;
      y_d       = '0;
      base_d    = '0;
      err_acc_d = 1'b0;
      w_addr_d  = '0;
      if (CAPTURE_EN) begin
        state_d = ST_WAIT_LINE;
        mode_d  = mode_e'(MODE);
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vsync_rise && CAPTURE_EN) begin
            state_d = ST_WAIT_LINE;
            mode_d  = mode_e'(MODE);
          end
        end
        ST_WAIT_LINE: begin
          if (CAM_HREF) begin
            state_d = ST_BYTE0;
            b0_d    = CAM_DATA;
          end
        end
        ST_BYTE0: begin
          if (CAM_HREF) begin
            // Pixel complete: write only inside the frame window, but always count it.
            state_d = ST_BYTE1;
            if ((x_q < FW_A) && (y_q < FH_A)) begin
              w_en_d   = 1'b1;
              w_data_d = pix;
              w_addr_d = base_q + x_q;
            end
            x_d = (x_q == CNT_MAX) ? x_q : x_q + 1'b1;
          end else begin
            // Line ended with a lone first byte: drop it and mark the frame bad.
            err_acc_d = 1'b1;
            line_end  = 1'b1;
          end
        end
        ST_BYTE1: begin
          if (CAM_HREF) begin
            state_d = ST_BYTE0;
            b0_d    = CAM_DATA;
          end else begin
            line_end = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (line_end) begin
        state_d = ST_WAIT_LINE;
        x_d     = '0;
        if (x_q != '0) begin
          if (x_q != FW_A) err_acc_d = 1'b1;
          y_d    = (y_q == CNT_MAX) ? y_q : y_q + 1'b1;
          base_d = base_sum[ADDR_W] ? CNT_MAX : base_sum[ADDR_W-1:0];
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_RGB565;
      vsync_q   <= 1'b0;
      b0_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      base_q    <= '0;
      err_acc_q <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_en_q    <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      vsync_q   <= vsync_d;
      b0_q      <= b0_d;
      x_q       <= x_d;
      y_q       <= y_d;
      base_q    <= base_d;
      err_acc_q <= err_acc_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_en_q    <= w_en_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign W_ADDR     = w_addr_q;
  assign W_DATA     = w_data_q;
  assign W_EN       = w_en_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a 4x2 frame.
// Latency: n/a.
// Backpressure: n/a.
module tb_camera_capture;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int AW = 15;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [7:0]    CAM_DATA;
  logic          CAM_HREF;
  logic          CAM_VSYNC;
  logic [1:0]    MODE;
  logic          CAPTURE_EN;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          W_EN;
  logic          FRAME_DONE;
  logic          FRAME_ERR;
  logic          BUSY;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wa[$];
  logic [7:0]    wd[$];
  int            done_cnt;
  logic          last_err;
  logic          busy_at_done;

  camera_capture #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CAM_DATA   (CAM_DATA),
    .CAM_HREF   (CAM_HREF),
    .CAM_VSYNC  (CAM_VSYNC),
    .MODE       (MODE),
    .CAPTURE_EN (CAPTURE_EN),
    .W_ADDR     (W_ADDR),
    .W_DATA     (W_DATA),
    .W_EN       (W_EN),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_ERR  (FRAME_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Log writes and frame completions on the falling edge.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (W_EN) begin
        wa.push_back(W_ADDR);
        wd.push_back(W_DATA);
      end
      if (FRAME_DONE) begin
        done_cnt++;
        last_err     = FRAME_ERR;
        busy_at_done = BUSY;
      end
    end
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt     = 0;
    last_err     = 1'bx;
    busy_at_done = 1'bx;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      CAM_HREF = 1'b0;
      CAM_DATA = 8'h00;
    end
  endtask

  task automatic vsync_pulse();
    @(negedge CLK);
    CAM_VSYNC = 1'b1;
    CAM_HREF  = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    CAM_VSYNC = 1'b0;
    idle(2);
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge CLK);
      CAM_HREF = 1'b1;
      CAM_DATA = (i % 2 == 0) ? b0 : b1;
    end
    idle(2);
  endtask

  task automatic start_frame(input logic [1:0] m);
    MODE       = m;
    CAPTURE_EN = 1'b1;
    vsync_pulse();
  endtask

  task automatic end_frame(input logic en);
    CAPTURE_EN = en;
    vsync_pulse();
  endtask

  task automatic test_reset();
    total++; if (W_EN !== 1'b0) begin bad++; $display("FAIL rst_wen: got %b want 0", W_EN); end
    total++; if (W_ADDR !== '0) begin bad++; $display("FAIL rst_waddr: got %0d want 0", W_ADDR); end
    total++; if (W_DATA !== 8'h00) begin bad++; $display("FAIL rst_wdata: got %h want 00", W_DATA); end
    total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", FRAME_DONE); end
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", FRAME_ERR); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    @(negedge CLK);
    RESET = 1'b0;
    clear_log();
    // VSYNC edge with capture disarmed: no frame, no done pulse.
    CAPTURE_EN = 1'b0;
    vsync_pulse();
    send_line(8, 8'hE7, 8'h18);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", BUSY); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL idle_done: got %0d want 0", done_cnt); end
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL idle_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_mode0_frame();
    clear_log();
    start_frame(2'd0);
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL m0_busy: got %b want 1", BUSY); end
    send_line(8, 8'hE7, 8'h18);
    send_line(8, 8'hE7, 8'h18);
    end_frame(1'b0);
    total++; if (wa.size() !== 8) begin bad++; $display("FAIL m0_count: got %0d want 8", wa.size()); end
    if (wa.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (wa[i] !== i[AW-1:0]) begin bad++; $display("FAIL m0_addr[%0d]: got %0d want %0d", i, wa[i], i); end
        total++; if (wd[i] !== 8'hFF) begin bad++; $display("FAIL m0_data[%0d]: got %h want ff", i, wd[i]); end
      end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL m0_done: got %0d want 1", done_cnt); end
    total++; if (last_err !== 1'b0) begin bad++; $display("FAIL m0_err: got %b want 0", last_err); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL m0_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_modes();
    // RGB444; MODE changed mid-frame must be ignored.
    clear_log();
    start_frame(2'd1);
    MODE = 2'd0;
    send_line(8, 8'h0A, 8'hF8);
    send_line(8, 8'h0A, 8'hF8);
    end_frame(1'b0);
    total++; if (wd.size() !== 8) begin bad++; $display("FAIL m1_count: got %0d want 8", wd.size()); end
    if (wd.size() == 8) begin
      total++; if (wd[0] !== 8'hBE) begin bad++; $display("FAIL m1_first: got %h want be", wd[0]); end
      total++; if (wd[7] !== 8'hBE) begin bad++; $display("FAIL m1_last: got %h want be", wd[7]); end
    end
    // YUV grayscale: only the first byte matters.
    clear_log();
    start_frame(2'd2);
    send_line(8, 8'h80, 8'h55);
    send_line(8, 8'h80, 8'h55);
    end_frame(1'b0);
    total++; if (wd.size() !== 8) begin bad++; $display("FAIL m2_count: got %0d want 8", wd.size()); end
    if (wd.size() == 8) begin
      total++; if (wd[3] !== 8'h92) begin bad++; $display("FAIL m2_data: got %h want 92", wd[3]); end
    end
    total++; if (last_err !== 1'b0) begin bad++; $display("FAIL m2_err: got %b want 0", last_err); end
    // Reserved mode decodes as RGB565: A5/5A -> 101_101_11.
    clear_log();
    start_frame(2'd3);
    send_line(8, 8'hA5, 8'h5A);
    send_line(8, 8'hA5, 8'h5A);
    end_frame(1'b0);
    total++; if (wd.size() !== 8) begin bad++; $display("FAIL m3_count: got %0d want 8", wd.size()); end
    if (wd.size() == 8) begin
      total++; if (wd[5] !== 8'hB7) begin bad++; $display("FAIL m3_data: got %h want b7", wd[5]); end
    end
  endtask

  task automatic test_overlong_line();
    clear_log();
    start_frame(2'd0);
    send_line(12, 8'hE7, 8'h18);
    send_line(8, 8'hE7, 8'h18);
    end_frame(1'b0);
    total++; if (wa.size() !== 8) begin bad++; $display("FAIL long_count: got %0d want 8", wa.size()); end
    if (wa.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (wa[i] !== i[AW-1:0]) begin bad++; $display("FAIL long_addr[%0d]: got %0d want %0d", i, wa[i], i); end
      end
    end
    total++; if (last_err !== 1'b1) begin bad++; $display("FAIL long_err: got %b want 1", last_err); end
  endtask

  task automatic test_partial_pixel();
    clear_log();
    start_frame(2'd0);
    send_line(9, 8'hE7, 8'h18);
    send_line(8, 8'hE7, 8'h18);
    end_frame(1'b0);
    total++; if (wa.size() !== 8) begin bad++; $display("FAIL part_count: got %0d want 8", wa.size()); end
    if (wa.size() == 8) begin
      total++; if (wa[3] !== 15'd3) begin bad++; $display("FAIL part_addr3: got %0d want 3", wa[3]); end
      total++; if (wa[4] !== 15'd4) begin bad++; $display("FAIL part_addr4: got %0d want 4", wa[4]); end
    end
    total++; if (last_err !== 1'b1) begin bad++; $display("FAIL part_err: got %b want 1", last_err); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    start_frame(2'd0);
    send_line(8, 8'hE7, 8'h18);
    end_frame(1'b1);
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL b2b_done1: got %0d want 1", done_cnt); end
    total++; if (last_err !== 1'b1) begin bad++; $display("FAIL b2b_err1: got %b want 1", last_err); end
    total++; if (busy_at_done !== 1'b1) begin bad++; $display("FAIL b2b_busy_done: got %b want 1", busy_at_done); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", BUSY); end
    clear_log();
    send_line(8, 8'hE7, 8'h18);
    send_line(8, 8'hE7, 8'h18);
    end_frame(1'b0);
    total++; if (wa.size() !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", wa.size()); end
    if (wa.size() == 8) begin
      total++; if (wa[0] !== 15'd0) begin bad++; $display("FAIL b2b_addr0: got %0d want 0", wa[0]); end
      total++; if (wa[7] !== 15'd7) begin bad++; $display("FAIL b2b_addr7: got %0d want 7", wa[7]); end
    end
    total++; if (last_err !== 1'b0) begin bad++; $display("FAIL b2b_err2: got %b want 0", last_err); end
  endtask

  task automatic test_capture_drop();
    clear_log();
    start_frame(2'd0);
    CAPTURE_EN = 1'b0;
    send_line(8, 8'hE7, 8'h18);
    send_line(8, 8'hE7, 8'h18);
    vsync_pulse();
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL drop_done: got %0d want 1", done_cnt); end
    total++; if (wa.size() !== 8) begin bad++; $display("FAIL drop_count: got %0d want 8", wa.size()); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL drop_idle: got %b want 0", BUSY); end
    clear_log();
    vsync_pulse();
    send_line(8, 8'hE7, 8'h18);
    send_line(8, 8'hE7, 8'h18);
    vsync_pulse();
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL drop_next_writes: got %0d want 0", wa.size()); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL drop_next_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_reset_mid_line();
    start_frame(2'd0);
    @(negedge CLK);
    CAM_HREF = 1'b1;
    CAM_DATA = 8'hE7;
    @(negedge CLK);
    CAM_DATA = 8'h18;
    @(posedge CLK);
    #2;
    total++; if (W_EN !== 1'b1) begin bad++; $display("FAIL mid_wen_pre: got %b want 1", W_EN); end
    RESET = 1'b1;
    #1;
    total++; if (W_EN !== 1'b0) begin bad++; $display("FAIL mid_wen: got %b want 0", W_EN); end
    total++; if (W_DATA !== 8'h00) begin bad++; $display("FAIL mid_wdata: got %h want 00", W_DATA); end
    total++; if (W_ADDR !== '0) begin bad++; $display("FAIL mid_waddr: got %0d want 0", W_ADDR); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", BUSY); end
    total++; if (FRAME_DONE !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", FRAME_DONE); end
    total++; if (FRAME_ERR !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", FRAME_ERR); end
    @(negedge CLK);
    RESET    = 1'b0;
    CAM_HREF = 1'b0;
    clear_log();
    send_line(8, 8'hE7, 8'h18);
    total++; if (wa.size() !== 0) begin bad++; $display("FAIL mid_no_writes: got %0d want 0", wa.size()); end
    start_frame(2'd0);
    send_line(8, 8'hE7, 8'h18);
    end_frame(1'b0);
    total++; if (wa.size() !== 4) begin bad++; $display("FAIL mid_resume_count: got %0d want 4", wa.size()); end
    if (wa.size() == 4) begin
      total++; if (wa[0] !== 15'd0) begin bad++; $display("FAIL mid_resume_addr: got %0d want 0", wa[0]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL mid_resume_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    RESET      = 1'b1;
    CAM_DATA   = 8'h00;
    CAM_HREF   = 1'b0;
    CAM_VSYNC  = 1'b0;
    MODE       = 2'd0;
    CAPTURE_EN = 1'b0;
    clear_log();
    repeat (3) @(negedge CLK);
    test_reset();
    test_mode0_frame();
    test_modes();
    test_overlong_line();
    test_partial_pixel();
    test_back_to_back();
    test_capture_drop();
    test_reset_mid_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
